delay_line_capture_fifo: RTL and testbench
==========================================

// Module: delay_line_capture_fifo
// PURPOSE
//  Downstream stage of the shift-register delay bank. Captures every word the bank
//  flags with DVALID into a synchronous FIFO and presents it on a ready/valid read
//  port, so the RISC-V core or a bus bridge can drain delayed samples at its own pace.
//  Words that arrive while the FIFO is full are dropped and counted; nothing stalls the bank.
// PARAMETERS
//  WIDTH    8    data word width; must equal the WIDTH of the delay bank feeding it
//  DEPTH    16   FIFO entries; power of two, >= 2
//  ADDR_W   $clog2(DEPTH)   derived localparam, not overridable
// PORTS
//  CLK          in   1         single clock, rising edge
//  RESET        in   1         synchronous, active-high
//  DATA_IN      in   WIDTH     word from the delay bank's DATA_OUT
//  DVALID_IN    in   1         qualifier from the delay bank's DVALID; push request
//  FLUSH        in   1         synchronous clear of the FIFO contents
//  CLR_OVERFLOW in   1         clears OVERFLOW and DROP_CNT
//  RD_READY     in   1         consumer accepts RD_DATA this cycle
//  RD_DATA      out  WIDTH     head-of-FIFO word (first-word fall-through)
//  RD_VALID     out  1         RD_DATA holds a valid word (== !EMPTY)
//  COUNT        out  ADDR_W+1  current occupancy, 0..DEPTH
//  FULL         out  1         COUNT == DEPTH
//  EMPTY        out  1         COUNT == 0
//  OVERFLOW     out  1         sticky: at least one word dropped since last clear
//  DROP_CNT     out  8         dropped-word count, saturates at 255
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, COUNT=0, EMPTY=1, FULL=0, RD_VALID=0, OVERFLOW=0, DROP_CNT=0.
//    RD_DATA is don't-care while RD_VALID=0. Storage array is not reset.
//  - pop  = RD_VALID & RD_READY. Advances rd_ptr; RD_DATA shows the next entry after the edge.
//  - push = DVALID_IN & (!FULL | pop). Writes DATA_IN at wr_ptr and advances wr_ptr.
//  - Latency: a word pushed at edge N is on RD_DATA with RD_VALID=1 from edge N onward
//    when the FIFO was empty. There is no bypass: an empty FIFO never pops in the push cycle.
//  - Push and pop in the same cycle: COUNT unchanged. This is legal when FULL.
//  - Drop = DVALID_IN & FULL & !pop. DATA_IN is discarded, OVERFLOW<=1,
//    DROP_CNT<=min(DROP_CNT+1,255).
//  - Pointers are ADDR_W bits and wrap naturally mod DEPTH. COUNT is tracked explicitly (+1/-1/0).
//  - Priority each cycle: RESET > FLUSH > normal push/pop.
//  - FLUSH: pointers and COUNT return to 0, and any push or pop that cycle is ignored.
//    FLUSH does not touch OVERFLOW or DROP_CNT.
//  - CLR_OVERFLOW concurrent with a drop: set wins, OVERFLOW=1 and DROP_CNT=1.
//  - RESET asserted mid-burst: contents are lost and outputs take reset values on the next edge.
//    DVALID_IN in the reset cycle is ignored.
//  - RD_READY while RD_VALID=0 has no effect.
// STRUCTURE
//  - Shared package ecu_stream_pkg holds the data width default (ECU_SAMPLE_W=8) and
//    the DROP_CNT width (ECU_DROP_CNT_W=8), reused by the delay bank and bus bridge.
//  - One natural sub-module is fifo_ptr_ctrl. It owns the pointers, COUNT, FULL/EMPTY and
//    the push/pop/drop decode, and exports the wr_en, wr_addr and rd_addr strobes.
//    The top level holds the storage array, the overflow/drop logic and the port muxing.
// TESTING
//  1. Reset, then push 0x11,0x22,0x33 with RD_READY=0 -> COUNT=3, RD_DATA=0x11;
//     raise RD_READY 3 cycles -> reads 0x11,0x22,0x33, EMPTY=1.
//  2. DEPTH=16: push 18 words 0x00..0x11, no reads -> FULL=1, OVERFLOW=1, DROP_CNT=2;
//     drain -> 0x00..0x0F in order.
//  3. FULL, with DVALID_IN=1 and RD_READY=1 for 4 cycles -> COUNT stays 16, no drop,
//     read order preserved across pointer wrap.
//  4. COUNT=5, assert FLUSH with DVALID_IN=1 -> next cycle COUNT=0, EMPTY=1, RD_VALID=0,
//     OVERFLOW unchanged.
//  5. Set OVERFLOW, then CLR_OVERFLOW with no drop -> OVERFLOW=0, DROP_CNT=0.
//     CLR_OVERFLOW together with a drop -> OVERFLOW=1, DROP_CNT=1.
//  6. Force 300 drops -> DROP_CNT=255 (saturates). RESET mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/ecu_stream_pkg.sv
// Shared stream definitions for the ECU delay-bank datapath: sample width,
// drop-counter width and the FIFO per-cycle operation encoding.
package ecu_stream_pkg;

  localparam int ECU_SAMPLE_W   = 8;
  localparam int ECU_DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    FIFO_IDLE     = 2'b00,
    FIFO_PUSH     = 2'b01,
    FIFO_POP      = 2'b10,
    FIFO_PUSH_POP = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy controller for the capture FIFO: decodes push, pop and drop
// each cycle and exports write strobe plus read/write addresses.
module fifo_ptr_ctrl
  import ecu_stream_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush,
  input  logic              push_req,
  input  logic              rd_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              drop,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_r;
  logic              pop;
  logic              push;
  fifo_op_e          op;

  assign full  = (count_r == (ADDR_W+1)'(DEPTH));
  assign empty = (count_r == '0);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  // An empty FIFO never pops, so there is no write-to-read bypass.
  always_comb begin
    pop  = !empty && rd_ready;
    push = push_req && (!full || pop);
    drop = 1'b0;
    op   = FIFO_IDLE;
    if (!RESET && !flush) begin
      drop = push_req && full && !pop;
      op   = fifo_op_e'({pop, push});
    end
  end

  assign wr_en   = (op == FIFO_PUSH) || (op == FIFO_PUSH_POP);
  assign wr_addr = wr_ptr;
  assign rd_addr = rd_ptr;
  assign count   = count_r;

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      case (op)
        FIFO_PUSH: begin
          wr_ptr  <= wr_ptr + ADDR_W'(1);
          count_r <= count_r + (ADDR_W+1)'(1);
        end
        FIFO_POP: begin
          rd_ptr  <= rd_ptr + ADDR_W'(1);
          count_r <= count_r - (ADDR_W+1)'(1);
        end
        FIFO_PUSH_POP: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/delay_line_capture_fifo.sv
// Capture FIFO behind the delay bank: stores every DVALID word, presents it on a
// first-word fall-through ready/valid port, and counts words lost while full.
module delay_line_capture_fifo
  import ecu_stream_pkg::*;
#(
  parameter int WIDTH = ECU_SAMPLE_W,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [WIDTH-1:0]          DATA_IN,
  input  logic                      DVALID_IN,
  input  logic                      FLUSH,
  input  logic                      CLR_OVERFLOW,
  input  logic                      RD_READY,
  output logic [WIDTH-1:0]          RD_DATA,
  output logic                      RD_VALID,
  output logic [ADDR_W:0]           COUNT,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic                      OVERFLOW,
  output logic [ECU_DROP_CNT_W-1:0] DROP_CNT
);

  function automatic logic [ECU_DROP_CNT_W-1:0] sat_inc(input logic [ECU_DROP_CNT_W-1:0] v);
    return (&v) ? v : v + ECU_DROP_CNT_W'(1);
  endfunction

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              drop;
  logic              empty_i;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic                      overflow_r;
  logic [ECU_DROP_CNT_W-1:0] drop_cnt_r;

  fifo_ptr_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ptr_ctrl (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush    (FLUSH),
    .push_req (DVALID_IN),
    .rd_ready (RD_READY),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .drop     (drop),
    .count    (COUNT),
    .full     (FULL),
    .empty    (empty_i)
  );

  // Storage is data-only and deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= DATA_IN;
    end
  end

  // A drop in the same cycle as a clear wins: the new drop restarts the count at 1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end else if (drop) begin
      overflow_r <= 1'b1;
      drop_cnt_r <= CLR_OVERFLOW ? ECU_DROP_CNT_W'(1) : sat_inc(drop_cnt_r);
    end else if (CLR_OVERFLOW) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end
  end

  assign RD_DATA  = mem[rd_addr];
  assign RD_VALID = !empty_i;
  assign EMPTY    = empty_i;
  assign OVERFLOW = overflow_r;
  assign DROP_CNT = drop_cnt_r;

endmodule

// File: tb/tb_delay_line_capture_fifo.sv
// Randomized and directed bench for delay_line_capture_fifo against a queue-based
// reference model of the capture/drop/flush rules.
module tb_delay_line_capture_fifo;

  localparam int W = 8;
  localparam int D = 16;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] DATA_IN = '0;
  logic         DVALID_IN = 1'b0;
  logic         FLUSH = 1'b0;
  logic         CLR_OVERFLOW = 1'b0;
  logic         RD_READY = 1'b0;
  logic [W-1:0] RD_DATA;
  logic         RD_VALID;
  logic [4:0]   COUNT;
  logic         FULL;
  logic         EMPTY;
  logic         OVERFLOW;
  logic [7:0]   DROP_CNT;

  delay_line_capture_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DATA_IN      (DATA_IN),
    .DVALID_IN    (DVALID_IN),
    .FLUSH        (FLUSH),
    .CLR_OVERFLOW (CLR_OVERFLOW),
    .RD_READY     (RD_READY),
    .RD_DATA      (RD_DATA),
    .RD_VALID     (RD_VALID),
    .COUNT        (COUNT),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .OVERFLOW     (OVERFLOW),
    .DROP_CNT     (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errs   = 0;

  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0;
  int           m_drops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_count"},    32'(COUNT),    32'(q.size()));
    chk({tag, "_empty"},    32'(EMPTY),    32'(q.size() == 0));
    chk({tag, "_full"},     32'(FULL),     32'(q.size() == D));
    chk({tag, "_rdvalid"},  32'(RD_VALID), 32'(q.size() != 0));
    chk({tag, "_overflow"}, 32'(OVERFLOW), 32'(m_ovf));
    chk({tag, "_dropcnt"},  32'(DROP_CNT), 32'(m_drops));
    if (q.size() != 0) chk({tag, "_rddata"}, 32'(RD_DATA), 32'(q[0]));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic cycle(input string tag, input logic dv, input logic [W-1:0] d,
                       input logic rdy, input logic fl, input logic clr, input logic rst);
    logic pop, full, drop;
    RESET = rst; DVALID_IN = dv; DATA_IN = d; RD_READY = rdy;
    FLUSH = fl; CLR_OVERFLOW = clr;
    if (rst) begin
      q.delete(); m_ovf = 1'b0; m_drops = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      pop  = (q.size() > 0) && rdy;
      full = (q.size() == D);
      drop = dv && full && !pop;
      if (pop) begin
        chk({tag, "_popdata"}, 32'(RD_DATA), 32'(q[0]));
        void'(q.pop_front());
      end
      if (dv && !drop) q.push_back(d);
      if (drop) begin
        m_ovf = 1'b1;
        m_drops = clr ? 1 : ((m_drops + 1 > 255) ? 255 : m_drops + 1);
      end else if (clr) begin
        m_ovf = 1'b0; m_drops = 0;
      end
    end
    @(posedge CLK);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    // Reset and reset-state values
    cycle("rst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("rst", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_count_const", 32'(COUNT), 32'd0);
    chk("rst_empty_const", 32'(EMPTY), 32'd1);

    // Test 1: three words, then read them back
    cycle("t1", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_latency_valid", 32'(RD_VALID), 32'd1);
    cycle("t1", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("t1", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_count3", 32'(COUNT), 32'd3);
    chk("t1_head", 32'(RD_DATA), 32'h11);
    for (int i = 0; i < 3; i++) cycle("t1rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_empty", 32'(EMPTY), 32'd1);
    cycle("t1idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Test 2: overfill by two
    for (int i = 0; i < 18; i++) cycle("t2", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_full", 32'(FULL), 32'd1);
    chk("t2_ovf", 32'(OVERFLOW), 32'd1);
    chk("t2_drops", 32'(DROP_CNT), 32'd2);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 32'(RD_DATA), 32'(i));
      cycle("t2rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Test 3: simultaneous push/pop while full, across pointer wrap
    for (int i = 0; i < 16; i++) cycle("t3fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("t3", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_count16", 32'(COUNT), 32'd16);
    chk("t3_nodrop", 32'(DROP_CNT), 32'd2);
    chk("t3_head", 32'(RD_DATA), 32'h44);
    for (int i = 0; i < 11; i++) cycle("t3rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Test 4: flush with a concurrent push
    chk("t4_count5", 32'(COUNT), 32'd5);
    cycle("t4", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_empty", 32'(EMPTY), 32'd1);
    chk("t4_ovf_kept", 32'(OVERFLOW), 32'd1);

    // Test 5: clear without a drop, then clear together with a drop
    cycle("t5clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_ovf0", 32'(OVERFLOW), 32'd0);
    for (int i = 0; i < 16; i++) cycle("t5fill", 1'b1, 8'(i * 3), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("t5drop", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("t5both", 1'b1, 8'h98, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_ovf1", 32'(OVERFLOW), 32'd1);
    chk("t5_drop1", 32'(DROP_CNT), 32'd1);

    // Test 6: saturation, then reset mid-stream
    for (int i = 0; i < 300; i++) cycle("t6", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_sat", 32'(DROP_CNT), 32'd255);
    cycle("t6rst", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("t6_rst_count", 32'(COUNT), 32'd0);

    // Randomized traffic in phases of varying push/pop pressure
    for (int ph = 0; ph < 8; ph++) begin
      int pv, pr;
      pv = 20 + 10 * ph;
      pr = 90 - 10 * ph;
      for (int i = 0; i < 250; i++) begin
        logic dv, rdy, fl, clr, rst;
        dv  = ($urandom_range(99) < pv);
        rdy = ($urandom_range(99) < pr);
        fl  = ($urandom_range(199) == 0);
        clr = ($urandom_range(49) == 0);
        rst = ($urandom_range(599) == 0);
        cycle("rand", dv, 8'($urandom), rdy, fl, clr, rst);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
